inst_sequencer: RTL

INST_SEQUENCER -- requirements
Module: inst_sequencer

---
 rtl/seq_pkg.sv | 30 +++
 rtl/inst_fields.sv | 21 ++
 rtl/inst_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// instruction-word field positions and special encodings.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT,
        S_ERR
    } state_t;

    localparam int IMM_LSB = 0;
    localparam int IMM_MSB = 8;
    localparam int RT_LSB  = 9;
    localparam int RT_MSB  = 14;
    localparam int OP_LSB  = 15;
    localparam int OP_MSB  = 18;
    localparam int RS_LSB  = 19;
    localparam int RS_MSB  = 24;
    localparam int RD_LSB  = 25;
    localparam int RD_MSB  = 30;
    localparam int SEL_BIT = 31;

    localparam logic [31:0] HALT_WORD = 32'h0000_0000;
    localparam logic [3:0]  NOP_OP    = 4'b0000;

endpackage

// File: rtl/inst_fields.sv
// Combinational field slicer for a 32-bit instruction word.
module inst_fields
    import seq_pkg::*;
(
    input  logic [31:0] word,
    output logic [5:0]  rs,
    output logic [5:0]  rt,
    output logic [5:0]  rd,
    output logic [3:0]  op,
    output logic        sel,
    output logic [15:0] imm
);

    assign rs  = word[RS_MSB:RS_LSB];
    assign rt  = word[RT_MSB:RT_LSB];
    assign rd  = word[RD_MSB:RD_LSB];
    assign op  = word[OP_MSB:OP_LSB];
    assign sel = word[SEL_BIT];
    assign imm = {7'b0, word[IMM_MSB:IMM_LSB]};

endmodule

// File: rtl/inst_sequencer.sv
// Fetch/decode/execute/writeback sequencer: fetches instruction words,
// holds them in IR and presents register-file and ALU controls.
module inst_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [5:0]      rf_ra1,
    output logic [5:0]      rf_ra2,
    output logic [5:0]      rf_wa,
    output logic            rf_we,
    output logic [3:0]      alu_op,
    output logic            mux_sel,
    output logic [15:0]     imm,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            error
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t              state, state_next;
    logic [PC_W-1:0]     pc_q, pc_next;
    logic [31:0]         ir, ir_next;
    logic [WAIT_W-1:0]   wait_cnt, wait_next;

    // Decode outputs are wired straight from IR, so they only move when IR loads.
    inst_fields u_fields (
        .word (ir),
        .rs   (rf_ra1),
        .rt   (rf_ra2),
        .rd   (rf_wa),
        .op   (alu_op),
        .sel  (mux_sel),
        .imm  (imm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc_q     <= '0;
            ir       <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            pc_q     <= pc_next;
            ir       <= ir_next;
            wait_cnt <= wait_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        ir_next    = ir;
        wait_next  = wait_cnt;
        imem_req   = 1'b0;
        rf_we      = 1'b0;

        unique case (state)
            S_IDLE, S_HALT, S_ERR: begin
                if (start) begin
                    state_next = S_FETCH;
                    pc_next    = '0;
                    wait_next  = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_next    = imem_data;
                    pc_next    = pc_q + PC_W'(1);
                    wait_next  = '0;
                    state_next = S_DECODE;
                end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                    state_next = S_ERR;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                state_next = (ir == HALT_WORD) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_next = S_WB;
            end
            S_WB: begin
                rf_we      = (alu_op != NOP_OP);
                wait_next  = '0;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                       (state == S_EXEC)  || (state == S_WB);
    assign halted    = (state == S_HALT);
    assign error     = (state == S_ERR);

endmodule
